// File: rtl/lru_age_table.sv
// True-LRU age store for a WAYS-way, SETS-set cache: registered victim lookup,
// one-hot touch updates, and a self-sequenced initialise/flush walk.
module lru_age_table #(
    parameter int WAYS = 8,
    parameter int SETS = 64,
    parameter int AW   = $clog2(WAYS),
    parameter int SW   = $clog2(SETS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    output logic            o_busy,
    input  logic            i_lkp_valid,
    input  logic [SW-1:0]   i_lkp_set,
    input  logic [WAYS-1:0] i_lkp_valid_ways,
    output logic            o_rsp_valid,
    output logic [WAYS-1:0] o_victim_onehot,
    output logic [AW-1:0]   o_victim_idx,
    input  logic            i_upd_valid,
    input  logic [SW-1:0]   i_upd_set,
    input  logic [WAYS-1:0] i_upd_way,
    output logic            o_upd_err
);

    // state   | meaning
    // ST_INIT | walking sets, writing identity ages; requests dropped
    // ST_RUN  | serving lookups and touch updates
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      cnt, cnt_nxt;
    logic               walk_we;
    logic [WAYS*AW-1:0] age_mem [SETS];

    logic               run_ok, upd_req, upd_legal, upd_we, lkp_go;
    logic [WAYS*AW-1:0] id_ages, upd_old, upd_ages, lkp_ages;
    logic [AW-1:0]      upd_age;
    logic [WAYS-1:0]    vic_oh;
    logic [AW-1:0]      vic_idx;
    logic               found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_flush) begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
        end else if (state == ST_INIT) begin
            if (cnt == SW'(SETS - 1)) begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + SW'(1);
            end
        end
    end

    always_comb begin
        o_busy  = (state == ST_INIT);
        walk_we = (state == ST_INIT) && !i_flush;
    end

    assign run_ok    = (state == ST_RUN) && !i_flush;
    assign upd_req   = run_ok && i_upd_valid;
    assign upd_legal = $onehot(i_upd_way);
    assign upd_we    = upd_req && upd_legal;
    assign lkp_go    = run_ok && i_lkp_valid;

    always_comb begin
        id_ages = '0;
        for (int i = 0; i < WAYS; i++) id_ages[i*AW +: AW] = AW'(i);
    end

    // Touched way becomes MRU; only ways younger than it shift down by one.
    always_comb begin
        upd_old  = age_mem[i_upd_set];
        upd_age  = '0;
        upd_ages = '0;
        for (int i = 0; i < WAYS; i++)
            if (i_upd_way[i]) upd_age = upd_age | upd_old[i*AW +: AW];
        for (int i = 0; i < WAYS; i++) begin
            if (i_upd_way[i])
                upd_ages[i*AW +: AW] = AW'(WAYS - 1);
            else if (upd_old[i*AW +: AW] > upd_age)
                upd_ages[i*AW +: AW] = upd_old[i*AW +: AW] - AW'(1);
            else
                upd_ages[i*AW +: AW] = upd_old[i*AW +: AW];
        end
    end

    // Same-set bypass so a lookup sees the update accepted on the same edge.
    always_comb begin
        if (upd_we && (i_upd_set == i_lkp_set)) lkp_ages = upd_ages;
        else                                    lkp_ages = age_mem[i_lkp_set];
        vic_oh  = '0;
        vic_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !i_lkp_valid_ways[i]) begin
                vic_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < WAYS; i++)
                if (lkp_ages[i*AW +: AW] == '0) vic_oh[i] = 1'b1;
        end
        for (int i = 0; i < WAYS; i++)
            if (vic_oh[i]) vic_idx = vic_idx | AW'(i);
    end

    always_ff @(posedge clk) begin
        if (walk_we)
            age_mem[cnt] <= id_ages;
        else if (upd_we)
            age_mem[i_upd_set] <= upd_ages;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rsp_valid     <= 1'b0;
            o_victim_onehot <= '0;
            o_victim_idx    <= '0;
            o_upd_err       <= 1'b0;
        end else begin
            o_rsp_valid <= lkp_go;
            o_upd_err   <= upd_req && !upd_legal;
            if (lkp_go) begin
                o_victim_onehot <= vic_oh;
                o_victim_idx    <= vic_idx;
            end
        end
    end

endmodule

// File: tb/tb_lru_age_table.sv
// Bench for lru_age_table (WAYS=8, SETS=4): directed steps plus random traffic
// checked against a recency-ordered list model of each set.
module tb_lru_age_table;

    localparam int WAYS = 8;
    localparam int SETS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_flush;
    logic       o_busy;
    logic       i_lkp_valid;
    logic [1:0] i_lkp_set;
    logic [7:0] i_lkp_valid_ways;
    logic       o_rsp_valid;
    logic [7:0] o_victim_onehot;
    logic [2:0] o_victim_idx;
    logic       i_upd_valid;
    logic [1:0] i_upd_set;
    logic [7:0] i_upd_way;
    logic       o_upd_err;

    int n_assert = 0;
    int n_fail   = 0;

    // ord[s][0] is least recently used, ord[s][7] most recently used
    int         ord [SETS][WAYS];
    int         busy_left;
    logic [7:0] last_oh;
    int         last_idx;

    lru_age_table #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (i_flush),
        .o_busy           (o_busy),
        .i_lkp_valid      (i_lkp_valid),
        .i_lkp_set        (i_lkp_set),
        .i_lkp_valid_ways (i_lkp_valid_ways),
        .o_rsp_valid      (o_rsp_valid),
        .o_victim_onehot  (o_victim_onehot),
        .o_victim_idx     (o_victim_idx),
        .i_upd_valid      (i_upd_valid),
        .i_upd_set        (i_upd_set),
        .i_upd_way        (i_upd_way),
        .o_upd_err        (o_upd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int s = 0; s < SETS; s++)
            for (int i = 0; i < WAYS; i++) ord[s][i] = i;
    endtask

    task automatic model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i < WAYS - 1; i++) ord[s][i] = ord[s][i+1];
        ord[s][WAYS-1] = w;
    endtask

    function automatic int model_victim(input int s, input logic [7:0] mask);
        for (int i = 0; i < WAYS; i++) if (!mask[i]) return i;
        return ord[s][0];
    endfunction

    task automatic req(input logic lv, input int ls, input logic [7:0] mask,
                       input logic uv, input int us, input logic [7:0] uw,
                       input logic fl);
        logic exp_rsp, exp_err;
        int   w, ones;
        i_lkp_valid      = lv;
        i_lkp_set        = 2'(ls);
        i_lkp_valid_ways = mask;
        i_upd_valid      = uv;
        i_upd_set        = 2'(us);
        i_upd_way        = uw;
        i_flush          = fl;
        @(posedge clk);
        #1;
        i_lkp_valid = 1'b0;
        i_upd_valid = 1'b0;
        i_flush     = 1'b0;
        exp_rsp = 1'b0;
        exp_err = 1'b0;
        if (fl) begin
            busy_left = SETS;
            model_init();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (uv) begin
                ones = 0;
                w = 0;
                for (int i = 0; i < WAYS; i++) if (uw[i]) begin ones++; w = i; end
                if (ones == 1) model_touch(us, w);
                else exp_err = 1'b1;
            end
            if (lv) begin
                last_idx = model_victim(ls, mask);
                last_oh  = 8'(1) << last_idx;
                exp_rsp  = 1'b1;
            end
        end
        check("rsp_valid", 32'(o_rsp_valid), 32'(exp_rsp));
        check("victim_onehot", 32'(o_victim_onehot), 32'(last_oh));
        check("victim_idx", 32'(o_victim_idx), 32'(last_idx));
        check("upd_err", 32'(o_upd_err), 32'(exp_err));
        check("busy", 32'(o_busy), 32'(busy_left > 0));
    endtask

    task automatic idle();
        req(1'b0, 0, 8'hFF, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic lookup(input int s, input logic [7:0] mask);
        req(1'b1, s, mask, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic touch(input int s, input logic [7:0] way);
        req(1'b0, 0, 8'hFF, 1'b1, s, way, 1'b0);
    endtask

    initial begin
        logic [7:0] mask, way;
        rst = 1'b0;
        i_flush = 1'b0;
        i_lkp_valid = 1'b0;
        i_lkp_set = '0;
        i_lkp_valid_ways = 8'hFF;
        i_upd_valid = 1'b0;
        i_upd_set = '0;
        i_upd_way = '0;
        last_oh = '0;
        last_idx = 0;
        model_init();
        #23;
        check("reset_busy", 32'(o_busy), 32'd1);
        check("reset_rsp", 32'(o_rsp_valid), 32'd0);
        check("reset_onehot", 32'(o_victim_onehot), 32'd0);
        check("reset_idx", 32'(o_victim_idx), 32'd0);
        check("reset_err", 32'(o_upd_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        busy_left = SETS;
        check("busy_after_release", 32'(o_busy), 32'd1);
        repeat (SETS) idle();
        check("walk_done", 32'(o_busy), 32'd0);

        lookup(2, 8'hFF);
        check("first_victim", 32'(o_victim_onehot), 32'h01);

        touch(1, 8'h08);
        lookup(1, 8'hFF);
        check("set1_after_touch3", 32'(o_victim_onehot), 32'h01);
        touch(1, 8'h01);
        lookup(1, 8'hFF);
        check("set1_after_touch0", 32'(o_victim_onehot), 32'h02);
        check("set1_after_touch0_idx", 32'(o_victim_idx), 32'd1);

        lookup(0, 8'b1111_0101);
        check("lowest_invalid", 32'(o_victim_onehot), 32'h02);
        lookup(0, 8'hFF);
        check("lookup_no_touch", 32'(o_victim_onehot), 32'h01);

        req(1'b1, 0, 8'hFF, 1'b1, 0, 8'h01, 1'b0);
        check("bypass_same_set", 32'(o_victim_onehot), 32'h02);
        req(1'b1, 3, 8'hFF, 1'b1, 0, 8'h02, 1'b0);
        check("other_set_indep", 32'(o_victim_onehot), 32'h01);

        req(1'b0, 0, 8'hFF, 1'b1, 1, 8'h03, 1'b0);
        check("multi_hot_err", 32'(o_upd_err), 32'd1);
        req(1'b1, 1, 8'hFF, 1'b1, 1, 8'h00, 1'b0);
        check("zero_way_err", 32'(o_upd_err), 32'd1);
        check("err_no_change", 32'(o_victim_onehot), 32'h02);
        idle();

        req(1'b1, 1, 8'hFF, 1'b1, 1, 8'h02, 1'b1);
        check("flush_busy", 32'(o_busy), 32'd1);
        for (int k = 0; k < SETS; k++) lookup(k, 8'hFF);
        for (int k = 0; k < SETS; k++) begin
            lookup(k, 8'hFF);
            check("post_flush_victim", 32'(o_victim_onehot), 32'h01);
        end

        for (int n = 0; n < 600; n++) begin
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 7) == 0) way = 8'($urandom);
            else way = 8'(1) << $urandom_range(0, 7);
            req(1'($urandom), int'($urandom_range(0, 3)), mask,
                1'($urandom), int'($urandom_range(0, 3)), way,
                ($urandom_range(0, 59) == 0));
        end

        while (busy_left > 0) idle();
        lookup(1, 8'hFF);
        rst = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(o_busy), 32'd1);
        check("midrun_reset_rsp", 32'(o_rsp_valid), 32'd0);
        check("midrun_reset_onehot", 32'(o_victim_onehot), 32'd0);
        check("midrun_reset_idx", 32'(o_victim_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        busy_left = SETS;
        last_oh = '0;
        last_idx = 0;
        model_init();
        repeat (SETS) idle();
        for (int k = 0; k < SETS; k++) begin
            lookup(k, 8'hFF);
            check("post_reset_victim", 32'(o_victim_onehot), 32'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lru_age_table.md
# lru_age_table

Parametrised true-LRU state store for a WAYS-way, SETS-set cache. It holds one age vector per set (age WAYS-1 = MRU, 0 = LRU), answers registered victim lookups, and applies touch updates from the cache controller. It prefers invalid ways on a victim lookup and has a self-sequenced initialise/flush walk. It replaces per-set combinational age calculation wired to external registers.

## Interface

Parameters:
- WAYS, 8, associativity; power of 2, 2..16
- SETS, 64, number of sets; ≥2
- AW, $clog2(WAYS), age and way-index width (derived, not overridden)
- SW, $clog2(SETS), set-index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_flush  in  1  pulse; restart the initialise walk
- o_busy  out  1  initialise walk in progress; requests ignored
- i_lkp_valid  in  1  victim lookup request
- i_lkp_set  in  SW  lookup set index
- i_lkp_valid_ways  in  WAYS  line-valid mask of the set; bit=0 means invalid
- o_rsp_valid  out  1  lookup response valid
- o_victim_onehot  out  WAYS  chosen victim way
- o_victim_idx  out  AW  binary index of victim
- i_upd_valid  in  1  touch update request
- i_upd_set  in  SW  update set index
- i_upd_way  in  WAYS  one-hot way touched (hit way or filled way)
- o_upd_err  out  1  pulse; update rejected, i_upd_way not one-hot

## Operation

- Storage: SETS × WAYS ages of AW bits, no reset on the array; content is defined only by the initialise walk.
- FSM states INIT and RUN.
  - Reset enters INIT with walk counter 0.
  - INIT writes set[counter] to identity ages (way i → age i) and increments the counter. After writing set SETS-1 → RUN.
  - i_flush in either state → INIT with counter 0. A flush in INIT restarts the walk.
- o_busy = (state == INIT). While busy, i_lkp_valid and i_upd_valid are dropped: no response, no error, no state change.
- Touch update (RUN, i_upd_valid, i_upd_way one-hot, touched way w, old age a = age[w]):
  - age[w] ← WAYS-1.
  - Every way with age > a decrements by 1.
  - Every way with age < a is unchanged.
  - Hits and miss fills use the same operation. A fill into the age-0 way decrements all other ways.
- Ages stay a permutation of 0..WAYS-1 after every legal update.
- i_upd_way zero or multi-hot: no state change; o_upd_err pulses 1 cycle.
- Victim lookup (RUN, i_lkp_valid):
  - If any bit of i_lkp_valid_ways is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is the way with age 0.
  - o_victim_idx is the binary encoding of o_victim_onehot.
- The block never applies an update by itself on lookup. The controller issues the touch for the filled way.
- Same-set collision: a lookup and an update to the same set in the same cycle are evaluated on the post-update ages (bypass). Different sets are independent.
- A flush asserted in the same cycle as a request takes priority; the request is dropped.

## Timing

- Reset values: o_busy=1, o_rsp_valid=0, o_victim_onehot=0, o_victim_idx=0, o_upd_err=0, state INIT, counter 0.
- Initialise walk lasts exactly SETS cycles after reset deassertion or a flush edge. o_busy falls on the cycle after set SETS-1 is written.
- Lookup latency is 1 cycle: a request at edge n gives o_rsp_valid=1 with the victim in cycle n+1. The response is a single-cycle pulse and may issue back-to-back every cycle.
- An update is written at the accepting edge. A lookup one cycle later, or the same cycle via bypass, sees it.
- o_upd_err is asserted the cycle after the illegal request, for 1 cycle.
- o_victim_onehot and o_victim_idx hold their last value when o_rsp_valid=0.
- Reset asserted mid-operation clears outputs immediately (asynchronously) and restarts the walk; in-flight responses are lost.

## Test plan

All scenarios use WAYS=8, SETS=4.

- Reset release → o_busy=1 for 4 cycles then 0. Lookup set 2, mask 8'hFF → next cycle o_rsp_valid=1, onehot 8'h01, idx 0.
- Set 1: touch way 3 → ages {0,1,2,7,3,4,5,6}; lookup → 8'h01. Touch way 0 → ages {7,0,1,6,2,3,4,5}; lookup → 8'h02, idx 1.
- Set 0 identity, mask 8'b11110101 → victim 8'h02 (lowest invalid way), ages unchanged by the lookup.
- Same cycle: update set 0 way 0 + lookup set 0, mask 8'hFF → response 8'h02. Lookup on set 3 in the same situation → 8'h01.
- Update with i_upd_way 8'h03 → o_upd_err pulses 1 cycle; next lookup returns the pre-request victim.
- After updates, pulse i_flush → o_busy=1 for 4 cycles. Lookups issued during busy give no o_rsp_valid; afterwards all sets return victim 8'h01.
